midi_parser: RTL and testbench
==============================

# midi_parser

Byte-stream MIDI decoder that sits directly downstream of the AVR serial receive path. It consumes `rx_data`/`new_rx_data` and turns channel-voice messages into single-word note/controller/pitch-bend events for the floppy-drive voice allocator. It handles running status, filters system real-time and SysEx traffic, and applies an optional channel filter. A one-entry output buffer with a valid/ready handshake decouples it from the consumer.

## Interface
- `OMNI`, default 1: 1 = accept all channels; 0 = emit only messages on `CHANNEL`.
- `CHANNEL`, default 0: channel number (0-15) used when `OMNI`=0.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_data`  in  8  received byte; valid only when `new_rx_data`=1.
- `new_rx_data`  in  1  one-cycle strobe, one byte per strobe.
- `ev_valid`  out  1  output buffer holds an event.
- `ev_ready`  in  1  consumer accepts; transfer occurs when `ev_valid && ev_ready`.
- `ev_kind`  out  2  0 = note off, 1 = note on, 2 = control change, 3 = pitch bend.
- `ev_channel`  out  4  MIDI channel of the event.
- `ev_data1`  out  7  note, controller number, or bend LSB.
- `ev_data2`  out  7  velocity, controller value, or bend MSB.
- `overflow`  out  1  one-cycle pulse: a completed event was dropped because the buffer was full.

## Operation
- Parser state machine states:
  - IDLE: no running status.
  - WAIT_D1 and WAIT_D2: running status held in the `status_q` register.
  - SYSEX.
- Byte classes are evaluated only on `new_rx_data`=1.
  - Real-time byte (0xF8-0xFF): ignored in every state; state, running status and any partial data are untouched.
  - Channel status byte (0x80-0xEF), any state: `status_q` <= byte; go to WAIT_D1; any partial message is discarded.
  - 0xF0: clear running status; go to SYSEX.
  - 0xF1-0xF7: clear running status; go to IDLE. 0xF7 also ends SysEx.
  - Data byte (0x00-0x7F):
    - IDLE or SYSEX: discarded.
    - WAIT_D1: latch `d1`.
      - Two-byte statuses (0x8n, 0x9n, 0xAn, 0xBn, 0xEn): go to WAIT_D2.
      - One-byte statuses (0xCn, 0xDn): message complete; stay in WAIT_D1.
    - WAIT_D2: latch `d2`; message complete; go to WAIT_D1 (running status retained).
- Any status byte 0x80-0xF7 received in SYSEX terminates SysEx and is then handled per its own class.
- On message completion, an event is emitted only if the type is 0x8n, 0x9n, 0xBn or 0xEn and (`OMNI`=1 or n==`CHANNEL`). 0xAn, 0xCn and 0xDn are consumed silently.
- Kind mapping:
  - 0x8n: kind 0.
  - 0x9n with velocity 0: kind 0, `ev_data2`=0.
  - 0x9n with velocity ≠ 0: kind 1.
  - 0xBn: kind 2.
  - 0xEn: kind 3, `ev_data1`=LSB, `ev_data2`=MSB.
- Output buffer:
  - Empty, or being drained in the same cycle (`ev_valid && ev_ready`): the new event is loaded and `ev_valid` stays or goes 1 with no bubble.
  - Full and not draining: the new event is dropped, `overflow` pulses, and the held event is unchanged.
  - A transfer with no new event clears `ev_valid`.
- Event fields are stable while `ev_valid`=1 and not accepted.

## Timing
- Reset values:
  - State IDLE, `status_q`=0 (no running status), `d1`=0.
  - `ev_valid`=0; `ev_kind`, `ev_channel`, `ev_data1`, `ev_data2` all 0; `overflow`=0.
- Reset mid-message discards the partial message and any buffered event. The first data byte after reset is discarded.
- Latency: `ev_valid` rises in the cycle after the `new_rx_data` strobe carrying the final data byte (1 register stage).
- `overflow` is high for exactly the cycle in which `ev_valid` would have been loaded.
- Back-to-back `new_rx_data` on consecutive cycles is fully supported: one byte per cycle, with no stall input toward the serial receiver.
- `ev_ready` may be held high permanently; `ev_valid` then pulses one cycle per event.

## Test plan
- Reset, then 0x90 0x3C 0x64 with `ev_ready`=1 → one-cycle `ev_valid` the cycle after the last byte: kind 1, ch 0, d1 0x3C, d2 0x64.
- Running status: 0x91 0x40 0x7F 0x40 0x00 → two events: (kind 1, ch 1, 0x40, 0x7F), then (kind 0, ch 1, 0x40, 0x00).
- Real-time interleave: 0xE2 0xF8 0x01 0xFE 0x40 → single pitch-bend event (ch 2, d1 0x01, d2 0x40); no disturbance from the real-time bytes.
- SysEx and program change: 0xF0 0x12 0x34 0xF7 0x55 0xC0 0x05 0xB0 0x07 0x7F → only a CC event (ch 0, d1 0x07, d2 0x7F); 0x55 is discarded because running status was cleared.
- Backpressure: `ev_ready`=0, send two complete note-ons → first held unchanged, `overflow` pulses once for the second; raising `ev_ready` drains the first only.
- Channel filter: `OMNI`=0, `CHANNEL`=3, send 0x92 0x30 0x10 then 0x93 0x30 0x10 → only the channel-3 event emitted. Assert `rst` between 0x93 and 0x30 → no event; a subsequent 0x30 0x10 is also discarded.

Source files
------------

// File: rtl/midi_parser.sv
`default_nettype none
// ============================================================================
// Module   : midi_parser
// Brief    : MIDI byte-stream decoder. Turns channel-voice messages into
//            note/CC/pitch-bend events. Handles running status, filters
//            real-time and SysEx bytes, applies an optional channel filter,
//            and holds one event behind a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module midi_parser #(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] ev_kind,
  output logic [3:0] ev_channel,
  output logic [6:0] ev_data1,
  output logic [6:0] ev_data2,
  output logic       overflow
);

  localparam logic [1:0] C_IDLE    = 2'd0;
  localparam logic [1:0] C_WAIT_D1 = 2'd1;
  localparam logic [1:0] C_WAIT_D2 = 2'd2;
  localparam logic [1:0] C_SYSEX   = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;

  // Message-complete strobe and the data bytes of the completed message
  logic       w_done;
  logic [6:0] w_msg_d1;
  logic [6:0] w_msg_d2;

  // Decoded event for the output buffer
  logic       w_emit;
  logic [1:0] w_kind;

  logic       ev_valid_q, ev_valid_d;
  logic [1:0] kind_q, kind_d;
  logic [3:0] chan_q, chan_d;
  logic [6:0] evd1_q, evd1_d;
  logic [6:0] evd2_q, evd2_d;
  logic       ovf_q, ovf_d;

  // Parser state register: state, running status and first data byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= C_IDLE;
      status_q <= 8'h00;
      d1_q     <= 7'h00;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
    end
  end

  // Next-state logic: classify the incoming byte and advance the parser
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    w_done   = 1'b0;
    w_msg_d1 = d1_q;
    w_msg_d2 = 7'h00;
    if (new_rx_data) begin
      if (rx_data >= 8'hF8) begin
        // Real-time: leave everything untouched
      end else if (rx_data[7] && (rx_data < 8'hF0)) begin
        status_d = rx_data;
        state_d  = C_WAIT_D1;
      end else if (rx_data == 8'hF0) begin
        status_d = 8'h00;
        state_d  = C_SYSEX;
      end else if (rx_data[7]) begin
        // 0xF1-0xF7: system common, also terminates SysEx
        status_d = 8'h00;
        state_d  = C_IDLE;
      end else begin
        case (state_q)
          C_WAIT_D1: begin
            d1_d = rx_data[6:0];
            if ((status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD)) begin
              w_done   = 1'b1;
              w_msg_d1 = rx_data[6:0];
            end else begin
              state_d = C_WAIT_D2;
            end
          end
          C_WAIT_D2: begin
            w_done   = 1'b1;
            w_msg_d1 = d1_q;
            w_msg_d2 = rx_data[6:0];
            state_d  = C_WAIT_D1;
          end
          default: begin
            // IDLE / SYSEX: stray data bytes are dropped
          end
        endcase
      end
    end
  end

  // Output decode: decide whether the completed message becomes an event
  always_comb begin
    w_emit = 1'b0;
    w_kind = 2'd0;
    case (status_q[7:4])
      4'h8: begin w_emit = 1'b1; w_kind = 2'd0; end
      4'h9: begin w_emit = 1'b1; w_kind = (w_msg_d2 == 7'h00) ? 2'd0 : 2'd1; end
      4'hB: begin w_emit = 1'b1; w_kind = 2'd2; end
      4'hE: begin w_emit = 1'b1; w_kind = 2'd3; end
      default: begin w_emit = 1'b0; w_kind = 2'd0; end
    endcase
    w_emit = w_emit && w_done && (OMNI || (status_q[3:0] == CHANNEL));
  end

  // Output buffer next value: load when empty or draining, else drop and flag
  always_comb begin
    ev_valid_d = ev_valid_q;
    kind_d     = kind_q;
    chan_d     = chan_q;
    evd1_d     = evd1_q;
    evd2_d     = evd2_q;
    ovf_d      = 1'b0;
    if (w_emit && (!ev_valid_q || ev_ready)) begin
      ev_valid_d = 1'b1;
      kind_d     = w_kind;
      chan_d     = status_q[3:0];
      evd1_d     = w_msg_d1;
      evd2_d     = w_msg_d2;
    end else if (w_emit) begin
      ovf_d = 1'b1;
    end else if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end
  end

  // Output buffer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid_q <= 1'b0;
      kind_q     <= 2'd0;
      chan_q     <= 4'd0;
      evd1_q     <= 7'h00;
      evd2_q     <= 7'h00;
      ovf_q      <= 1'b0;
    end else begin
      ev_valid_q <= ev_valid_d;
      kind_q     <= kind_d;
      chan_q     <= chan_d;
      evd1_q     <= evd1_d;
      evd2_q     <= evd2_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ev_valid   = ev_valid_q;
  assign ev_kind    = kind_q;
  assign ev_channel = chan_q;
  assign ev_data1   = evd1_q;
  assign ev_data2   = evd2_q;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_midi_parser
// Brief    : Directed self-checking bench for midi_parser (omni instance and
//            a channel-3 filtered instance sharing one byte stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_midi_parser;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       new_rx_data;

  logic       valid_a, ready_a, ovf_a;
  logic [1:0] kind_a;
  logic [3:0] ch_a;
  logic [6:0] d1_a, d2_a;

  logic       valid_b, ready_b, ovf_b;
  logic [1:0] kind_b;
  logic [3:0] ch_b;
  logic [6:0] d1_b, d2_b;

  int n_chk  = 0;
  int n_pass = 0;
  int ovf_cnt = 0;

  midi_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) u_dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .ev_valid(valid_a), .ev_ready(ready_a), .ev_kind(kind_a),
    .ev_channel(ch_a), .ev_data1(d1_a), .ev_data2(d2_a), .overflow(ovf_a)
  );

  midi_parser #(.OMNI(1'b0), .CHANNEL(4'd3)) u_dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .ev_valid(valid_b), .ev_ready(ready_b), .ev_kind(kind_b),
    .ev_channel(ch_b), .ev_data1(d1_b), .ev_data2(d2_b), .overflow(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count overflow pulses of the omni instance, sampled mid-cycle
  always @(negedge clk) if (ovf_a) ovf_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ev(input logic [1:0] k, input logic [3:0] c,
                                     input logic [6:0] a, input logic [6:0] b);
    return {12'h000, k, c, a, b};
  endfunction

  function automatic logic [31:0] fa();
    return {12'h000, kind_a, ch_a, d1_a, d2_a};
  endfunction

  function automatic logic [31:0] fb();
    return {12'h000, kind_b, ch_b, d1_b, d2_b};
  endfunction

  // One byte per clock; returns 1 time unit after the edge that took it
  task automatic send(input logic [7:0] b);
    rx_data     = b;
    new_rx_data = 1'b1;
    @(posedge clk);
    #1;
    new_rx_data = 1'b0;
  endtask

  task automatic idle(input int n);
    new_rx_data = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; new_rx_data = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_valid", valid_a, 0);
    chk("rst_fields", fa(), 0);
    chk("rst_ovf", ovf_a, 0);

    // Basic note on, one-cycle valid pulse
    send(8'h90); chk("t1_v0", valid_a, 0);
    send(8'h3C); chk("t1_v1", valid_a, 0);
    send(8'h64); chk("t1_valid", valid_a, 1);
    chk("t1_ev", fa(), ev(2'd1, 4'd0, 7'h3C, 7'h64));
    idle(1);     chk("t1_drop", valid_a, 0);

    // Running status, velocity 0 becomes note off
    send(8'h91); send(8'h40); send(8'h7F);
    chk("t2_valid1", valid_a, 1);
    chk("t2_ev1", fa(), ev(2'd1, 4'd1, 7'h40, 7'h7F));
    send(8'h40); chk("t2_mid", valid_a, 0);
    send(8'h00);
    chk("t2_valid2", valid_a, 1);
    chk("t2_ev2", fa(), ev(2'd0, 4'd1, 7'h40, 7'h00));
    idle(1);

    // Real-time bytes interleaved with pitch bend
    send(8'hE2); send(8'hF8); send(8'h01);
    chk("t3_v_d1", valid_a, 0);
    send(8'hFE); chk("t3_v_rt", valid_a, 0);
    send(8'h40);
    chk("t3_valid", valid_a, 1);
    chk("t3_ev", fa(), ev(2'd3, 4'd2, 7'h01, 7'h40));
    idle(1);

    // SysEx, stray data, silent program change, then CC
    send(8'hF0); send(8'h12); send(8'h34); send(8'hF7);
    chk("t4_sysex", valid_a, 0);
    send(8'h55); chk("t4_stray", valid_a, 0);
    send(8'hC0); send(8'h05); chk("t4_pc", valid_a, 0);
    send(8'hB0); send(8'h07); send(8'h7F);
    chk("t4_valid", valid_a, 1);
    chk("t4_ev", fa(), ev(2'd2, 4'd0, 7'h07, 7'h7F));
    idle(1);

    // Backpressure and overflow
    ready_a = 1'b0;
    ovf_cnt = 0;
    send(8'h90); send(8'h30); send(8'h40);
    chk("t5_valid", valid_a, 1);
    chk("t5_ovf0", ovf_a, 0);
    send(8'h90); send(8'h31); send(8'h41);
    chk("t5_ovf1", ovf_a, 1);
    chk("t5_held", fa(), ev(2'd1, 4'd0, 7'h30, 7'h40));
    idle(1);
    chk("t5_ovf_end", ovf_a, 0);
    chk("t5_still", valid_a, 1);
    chk("t5_held2", fa(), ev(2'd1, 4'd0, 7'h30, 7'h40));
    ready_a = 1'b1;
    idle(1);
    chk("t5_drained", valid_a, 0);
    idle(2);
    chk("t5_no_second", valid_a, 0);
    chk("t5_ovf_cnt", ovf_cnt, 1);

    // Drain and load in the same cycle: no bubble
    ready_a = 1'b0;
    send(8'h90); send(8'h50); send(8'h01);
    send(8'h90); send(8'h51);
    chk("t5b_held", fa(), ev(2'd1, 4'd0, 7'h50, 7'h01));
    ready_a = 1'b1;
    send(8'h02);
    chk("t5b_valid", valid_a, 1);
    chk("t5b_ev", fa(), ev(2'd1, 4'd0, 7'h51, 7'h02));
    chk("t5b_ovf", ovf_a, 0);
    idle(1);

    // Channel filter on the channel-3 instance, and reset mid-message
    do_reset();
    send(8'h92); send(8'h30); send(8'h10);
    chk("t6_ch2", valid_b, 0);
    chk("t6_omni_ch2", valid_a, 1);
    send(8'h93); send(8'h30); send(8'h10);
    chk("t6_ch3_valid", valid_b, 1);
    chk("t6_ch3_ev", fb(), ev(2'd1, 4'd3, 7'h30, 7'h10));
    idle(1);
    send(8'h93);
    do_reset();
    chk("t6_rst_valid", valid_b, 0);
    chk("t6_rst_fields", fb(), 0);
    send(8'h30); send(8'h10);
    chk("t6_after_rst", valid_b, 0);
    idle(1);
    chk("t6_after_rst2", valid_b, 0);
    send(8'h93); send(8'h31); send(8'h11);
    chk("t6_recover", fb(), ev(2'd1, 4'd3, 7'h31, 7'h11));
    chk("t6_recover_v", valid_b, 1);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
